fft8_stream: RTL and testbench
==============================

# fft8_stream

Streaming 8-point radix-2 decimation-in-time forward FFT. It is the analysis-side counterpart of the team's 8-point IFFT block. Complex time samples arrive over a valid/ready stream and are stored in bit-reversed order. The block computes 12 butterflies, one per cycle, through a single shared butterfly datapath, then streams the 8 frequency bins out in natural order. It sits between the sample front-end and the spectral processing/IFFT path.

## Interface
- DW, 16, input sample width (signed real and imag, each).
- OW, DW+4, output and internal working width (signed); covers worst-case complex growth of 8·√2.
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high.
- s_valid  input  1  input sample valid.
- s_ready  output  1  block accepts samples (LOAD state only).
- s_real  input  DW  sample real part, signed.
- s_imag  input  DW  sample imag part, signed.
- m_valid  output  1  output bin valid.
- m_ready  input  1  downstream accepts bin.
- m_real  output  OW  bin real part, signed.
- m_imag  output  OW  bin imag part, signed.
- m_index  output  3  bin number k (0..7).
- m_last  output  1  high with bin 7.
- busy  output  1  high in COMPUTE or UNLOAD.

## Operation
- States:
  - LOAD: s_ready=1. Sample n (n = count of accepted beats, 0..7) is written sign-extended to OW at address bitrev(n). The 8th accept moves to COMPUTE.
  - COMPUTE: butterfly counter b=0..11, one per cycle. Stage s=b/4 with span 2^s. Pair p=b%4 gives group g=p>>s and offset o=p&(span-1). Top address = g·2·span+o; bottom address = top+span. Twiddle exponent k=o·(4>>s). Results are written back in place. After b=11 the block moves to UNLOAD.
  - UNLOAD: presents bin m_index at address m_index. On m_valid&&m_ready, m_index increments. Acceptance of bin 7 returns the block to LOAD.
- Twiddles use the forward convention W8^k = e^(−j2πk/8). C = 23170 (Q1.15), rnd(x) = (x + 2^14) >>> 15.
  - k=0: bottom value is used unchanged.
  - k=2: (r,i) becomes (i, −r).
  - k=1: (rnd(C·(r+i)), rnd(C·(i−r))).
  - k=3: (rnd(C·(i−r)), −rnd(C·(r+i))).
  - Sums are formed at OW+1 bits before the multiply.
- Butterfly: top' = a + t and bottom' = a − t, truncated to OW. No saturation is needed at OW=DW+4.
- Reset values: s_ready=1 after reset release, m_valid=0, m_last=0, m_index=0, m_real=0, m_imag=0, busy=0. State is LOAD with all counters 0. Memory contents are don't-care.
- Reset in any state aborts the frame immediately. Partial data is discarded and no bin is emitted afterwards.
- s_valid during COMPUTE or UNLOAD is ignored (s_ready=0). Held m_ready=0 stalls UNLOAD indefinitely.

## Timing
- Call the edge that accepts sample 7 edge E.
- Butterflies write at edges E+1..E+12. m_valid rises after E+12, 12 cycles after the last input accept.
- Outputs are registered. m_real, m_imag, m_index and m_last are stable while m_valid=1 and m_ready=0.
- At full throughput (m_ready=1), bins are accepted at edges E+13..E+20. s_ready rises after edge E+20.
- Frame period at full throughput is 8+12+8 = 28 cycles.
- No overlap between frames: the first sample of the next frame is accepted no earlier than the cycle after bin 7 is accepted.

## Configuration
- FFT8_SCALE_EN defined: every butterfly output is arithmetically shifted right by 1 (floor) before write-back. Total scaling is 1/8. Output width stays OW, with values sign-extended.
- Undefined: unscaled output, so X0 of a DC input equals 8× the sample value.

## Structure
- Package fft8_pkg holds:
  - DW/OW defaults and C_Q15=23170.
  - The state enum {LOAD, COMPUTE, UNLOAD}.
  - A bitrev3 function.
  - A twiddle-exponent function of (s, p).
- Sub-module fft8_butterfly: a combinational twiddle-select, rotate and add/sub unit. It takes a, b and k and returns top' and bottom'. Scaling is applied inside it under FFT8_SCALE_EN.
- The top level holds the 8×2×OW register file, the counters, the FSM and the output registers.

## Test plan
- Impulse: x0=(1000,0), others 0, m_ready=1 → all 8 bins (1000,0), m_last on bin 7 only, m_valid rises exactly 12 cycles after edge E.
- DC: all samples (1000,0) → X0=(8000,0), bins 1..7 = (0,0). With FFT8_SCALE_EN → X0=(1000,0).
- Tone: x[n]=(round(8192·cos(2πn/8)), round(8192·sin(2πn/8))) → X1 within ±3 of (65536,0), every other bin component within ±3 of 0.
- Backpressure: random m_ready with 50% duty → bin values and order identical to m_ready=1, and outputs are held while stalled. s_valid during COMPUTE/UNLOAD → no sample is consumed.
- Reset mid-COMPUTE (at b=5) → m_valid stays 0 and s_ready=1 after release. The next full frame (DC 500) gives X0=(4000,0).
- Back-to-back frames with full-scale inputs (±32767/−32768 mixes) → outputs match the bit-accurate model with no wrap. The second frame's first accept falls exactly 1 cycle after bin 7 of the first frame is accepted.

Source files
------------

// File: rtl/fft8_pkg.sv
// fft8_pkg: widths, twiddle constant, FSM states and address helpers for fft8_stream
package fft8_pkg;
    localparam int DW = 16;
    localparam int OW = DW + 4;
    localparam int C_Q15 = 23170;

    typedef enum logic [1:0] {LOAD, COMPUTE, UNLOAD} state_t;

    function automatic logic [2:0] bitrev3(input logic [2:0] n);
        return {n[0], n[1], n[2]};
    endfunction

    // twiddle exponent o*(4>>s) with o = p & (span-1)
    function automatic logic [1:0] tw_exp(input logic [1:0] s, input logic [1:0] p);
        return (s == 2'd0) ? 2'd0 : (s == 2'd1) ? {p[0], 1'b0} : p;
    endfunction
endpackage

// File: rtl/fft8_stream_if.sv
// fft8_stream_if: sample-in / bin-out valid-ready bundle; slave = the FFT block, master = its environment
interface fft8_stream_if;
    logic                            s_valid;
    logic                            s_ready;
    logic signed [fft8_pkg::DW-1:0]  s_real;
    logic signed [fft8_pkg::DW-1:0]  s_imag;
    logic                            m_valid;
    logic                            m_ready;
    logic signed [fft8_pkg::OW-1:0]  m_real;
    logic signed [fft8_pkg::OW-1:0]  m_imag;
    logic [2:0]                      m_index;
    logic                            m_last;

    modport slave (
        input  s_valid, s_real, s_imag, m_ready,
        output s_ready, m_valid, m_real, m_imag, m_index, m_last
    );

    modport master (
        output s_valid, s_real, s_imag, m_ready,
        input  s_ready, m_valid, m_real, m_imag, m_index, m_last
    );
endinterface

// File: rtl/fft8_butterfly.sv
// fft8_butterfly: rotate b by W8^k then form a+t / a-t; FFT8_SCALE_EN halves both outputs (floor)
module fft8_butterfly
    import fft8_pkg::*;
(
    input  logic signed [OW-1:0] a_re,
    input  logic signed [OW-1:0] a_im,
    input  logic signed [OW-1:0] b_re,
    input  logic signed [OW-1:0] b_im,
    input  logic [1:0]           k,
    output logic signed [OW-1:0] top_re,
    output logic signed [OW-1:0] top_im,
    output logic signed [OW-1:0] bot_re,
    output logic signed [OW-1:0] bot_im
);
    localparam int PW = OW + 17;

    logic signed [OW:0]   spi, dif;
    logic signed [PW-1:0] p_spi, p_dif;
    logic signed [OW-1:0] r_spi, r_dif, t_re, t_im;

    // twiddle rotation; diagonal twiddles scale the one-bit-wider sums by C and round back
    always_comb begin
        spi   = {b_re[OW-1], b_re} + {b_im[OW-1], b_im};
        dif   = {b_im[OW-1], b_im} - {b_re[OW-1], b_re};
        p_spi = PW'(spi) * PW'(C_Q15);
        p_dif = PW'(dif) * PW'(C_Q15);
        r_spi = OW'((p_spi + PW'(16384)) >>> 15);
        r_dif = OW'((p_dif + PW'(16384)) >>> 15);
        t_re  = (k == 2'd0) ? b_re : (k == 2'd2) ? b_im : (k == 2'd1) ? r_spi : r_dif;
        t_im  = (k == 2'd0) ? b_im : (k == 2'd2) ? -b_re : (k == 2'd1) ? r_dif : -r_spi;
    end

`ifdef FFT8_SCALE_EN
    logic signed [OW:0] s_re, s_im, d_re, d_im;

    // full-width add/sub, then arithmetic halving back into OW
    always_comb begin
        s_re   = {a_re[OW-1], a_re} + {t_re[OW-1], t_re};
        s_im   = {a_im[OW-1], a_im} + {t_im[OW-1], t_im};
        d_re   = {a_re[OW-1], a_re} - {t_re[OW-1], t_re};
        d_im   = {a_im[OW-1], a_im} - {t_im[OW-1], t_im};
        top_re = OW'(s_re >>> 1);
        top_im = OW'(s_im >>> 1);
        bot_re = OW'(d_re >>> 1);
        bot_im = OW'(d_im >>> 1);
    end
`else
    // OW headroom covers full growth, so plain OW-wide add/sub never wraps
    always_comb begin
        top_re = a_re + t_re;
        top_im = a_im + t_im;
        bot_re = a_re - t_re;
        bot_im = a_im - t_im;
    end
`endif
endmodule

// File: rtl/fft8_stream.sv
// fft8_stream: streaming 8-point radix-2 DIT forward FFT, one shared butterfly; option macro FFT8_SCALE_EN
module fft8_stream
    import fft8_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    fft8_stream_if.slave io,
    output logic         busy
);
    state_t state, state_nxt;
    logic [2:0] n_cnt, top_a, bot_a, nxt_idx;
    logic [3:0] b_cnt;
    logic [1:0] stg, pr, tw_k;
    logic s_acc, m_acc, bf_done;
    logic signed [OW-1:0] mem_re [8];
    logic signed [OW-1:0] mem_im [8];
    logic signed [OW-1:0] top_re, top_im, bot_re, bot_im;

    assign io.s_ready = state == LOAD;
    assign busy       = state != LOAD;
    assign s_acc      = io.s_valid && io.s_ready;
    assign m_acc      = io.m_valid && io.m_ready;
    assign bf_done    = state == COMPUTE && b_cnt == 4'd11;
    assign nxt_idx    = io.m_index + 3'd1;

    // butterfly b -> stage b/4, pair b%4 -> in-place addresses and twiddle exponent
    always_comb begin
        stg   = b_cnt[3:2];
        pr    = b_cnt[1:0];
        top_a = (stg == 2'd0) ? {pr, 1'b0} : (stg == 2'd1) ? {pr[1], 1'b0, pr[0]} : {1'b0, pr};
        bot_a = (stg == 2'd0) ? {pr, 1'b1} : (stg == 2'd1) ? {pr[1], 1'b1, pr[0]} : {1'b1, pr};
        tw_k  = tw_exp(stg, pr);
    end

    fft8_butterfly u_bf (
        .a_re   (mem_re[top_a]),
        .a_im   (mem_im[top_a]),
        .b_re   (mem_re[bot_a]),
        .b_im   (mem_im[bot_a]),
        .k      (tw_k),
        .top_re (top_re),
        .top_im (top_im),
        .bot_re (bot_re),
        .bot_im (bot_im)
    );

    // state register; reset aborts any frame in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= LOAD;
        else       state <= state_nxt;
    end

    // next state: 8 accepts, 12 butterflies, 8 delivered bins
    always_comb begin
        state_nxt = state;
        case (state)
            LOAD:    if (s_acc && n_cnt == 3'd7) state_nxt = COMPUTE;
            COMPUTE: if (bf_done) state_nxt = UNLOAD;
            UNLOAD:  if (m_acc && io.m_index == 3'd7) state_nxt = LOAD;
            default: state_nxt = LOAD;
        endcase
    end

    // register file: samples land bit-reversed, butterflies write back in place
    always_ff @(posedge clk) begin
        if (s_acc) begin
            mem_re[bitrev3(n_cnt)] <= {{(OW-DW){io.s_real[DW-1]}}, io.s_real};
            mem_im[bitrev3(n_cnt)] <= {{(OW-DW){io.s_imag[DW-1]}}, io.s_imag};
        end else if (state == COMPUTE) begin
            mem_re[top_a] <= top_re;
            mem_im[top_a] <= top_im;
            mem_re[bot_a] <= bot_re;
            mem_im[bot_a] <= bot_im;
        end
    end

    // counters and registered output bin; bin 0 preloads as the last butterfly writes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            n_cnt      <= 3'd0;
            b_cnt      <= 4'd0;
            io.m_valid <= 1'b0;
            io.m_index <= 3'd0;
            io.m_last  <= 1'b0;
            io.m_real  <= '0;
            io.m_imag  <= '0;
        end else begin
            if (s_acc) n_cnt <= n_cnt + 3'd1;
            if (state == COMPUTE) b_cnt <= bf_done ? 4'd0 : b_cnt + 4'd1;
            if (bf_done) begin
                io.m_valid <= 1'b1;
                io.m_index <= 3'd0;
                io.m_last  <= 1'b0;
                io.m_real  <= mem_re[0];
                io.m_imag  <= mem_im[0];
            end else if (m_acc) begin
                io.m_valid <= io.m_index != 3'd7;
                io.m_index <= nxt_idx;
                io.m_last  <= nxt_idx == 3'd7;
                io.m_real  <= mem_re[nxt_idx];
                io.m_imag  <= mem_im[nxt_idx];
            end
        end
    end
endmodule

// File: tb/tb_fft8_stream.sv
// tb_fft8_stream: scoreboard bench for fft8_stream; expectations follow FFT8_SCALE_EN
module tb_fft8_stream;
    import fft8_pkg::*;

    typedef struct {
        longint re;
        longint im;
        longint tol;
        int     idx;
    } exp_t;

`ifdef FFT8_SCALE_EN
    localparam int SH = 3;
`else
    localparam int SH = 0;
`endif

    logic clk, reset, busy;
    fft8_stream_if io ();

    fft8_stream dut (
        .clk   (clk),
        .reset (reset),
        .io    (io),
        .busy  (busy)
    );

    exp_t   sb[$];
    exp_t   cur;
    int     n_tests = 0, n_fail = 0, cyc = 0, e_edge = 0, last_edge = 0, rdy_mode = 0;
    int     fa, fb;
    int     fr_re[8], fr_im[8];
    longint md_re[8], md_im[8];
    logic   pv = 1'b0, pstall = 1'b0;
    logic signed [OW-1:0] h_re, h_im;
    logic [2:0] h_idx;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        io.m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            io.m_ready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        end
    end

    task automatic chk(input string nm, input longint act, input longint exp, input longint tol);
        n_tests++;
        if (act - exp > tol || exp - act > tol) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d)", nm, act, exp, tol);
        end
    endtask

    task automatic fail(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s", nm);
    endtask

    task automatic push(input longint re, input longint im, input longint tol, input int idx);
        exp_t e;
        e.re = re;
        e.im = im;
        e.tol = tol;
        e.idx = idx;
        sb.push_back(e);
    endtask

    task automatic set_frame(input int re, input int im);
        for (int n = 0; n < 8; n++) begin
            fr_re[n] = re;
            fr_im[n] = im;
        end
    endtask

    function automatic longint rnd(input longint x);
        return (x + 16384) >>> 15;
    endfunction

    // reference DIT FFT over 64-bit integers, bins in natural order
    task automatic run_model();
        longint ar[8], ai[8];
        longint br, bi, tr, ti, xr, xi, yr, yi;
        int t, u, k, span;
        for (int n = 0; n < 8; n++) begin
            t = ((n & 1) << 2) | (n & 2) | ((n >> 2) & 1);
            ar[t] = fr_re[n];
            ai[t] = fr_im[n];
        end
        for (int s = 0; s < 3; s++) begin
            span = 1 << s;
            for (int g = 0; g < 8; g += 2 * span) begin
                for (int o = 0; o < span; o++) begin
                    t = g + o;
                    u = t + span;
                    k = o * (4 >> s);
                    br = ar[u];
                    bi = ai[u];
                    if (k == 0) begin tr = br; ti = bi; end
                    else if (k == 2) begin tr = bi; ti = -br; end
                    else if (k == 1) begin tr = rnd(C_Q15 * (br + bi)); ti = rnd(C_Q15 * (bi - br)); end
                    else begin tr = rnd(C_Q15 * (bi - br)); ti = -rnd(C_Q15 * (br + bi)); end
                    xr = ar[t] + tr;
                    xi = ai[t] + ti;
                    yr = ar[t] - tr;
                    yi = ai[t] - ti;
`ifdef FFT8_SCALE_EN
                    xr = xr >>> 1;
                    xi = xi >>> 1;
                    yr = yr >>> 1;
                    yi = yi >>> 1;
`endif
                    ar[t] = xr;
                    ai[t] = xi;
                    ar[u] = yr;
                    ai[u] = yi;
                end
            end
        end
        for (int n = 0; n < 8; n++) begin
            md_re[n] = ar[n];
            md_im[n] = ai[n];
        end
    endtask

    task automatic push_model();
        run_model();
        for (int n = 0; n < 8; n++) push(md_re[n], md_im[n], 0, n);
    endtask

    // offers fr_* as one frame; fe = edge number of the first accept
    task automatic send_frame(output int fe);
        int n, guard;
        n = 0;
        guard = 0;
        fe = 0;
        while (n < 8 && guard < 200) begin
            @(negedge clk);
            io.s_valid = 1'b1;
            io.s_real = DW'(fr_re[n]);
            io.s_imag = DW'(fr_im[n]);
            if (io.s_ready) begin
                if (n == 0) fe = cyc + 1;
                if (n == 7) e_edge = cyc + 1;
                n++;
            end
            guard++;
        end
        if (n < 8) fail("send_timeout");
        @(posedge clk);
        #1;
        io.s_valid = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (sb.size() > 0 && g < 500) begin
            @(negedge clk);
            g++;
        end
        if (sb.size() > 0) fail("drain_timeout");
        repeat (3) @(negedge clk);
    endtask

    // monitor: latency, hold-while-stalled, and scoreboard pop on every accepted bin
    always @(negedge clk) begin
        if (reset) begin
            pv <= 1'b0;
            pstall <= 1'b0;
        end else begin
            if (io.m_valid && !pv) chk("latency", longint'(cyc - e_edge), 12, 0);
            if (pstall && io.m_valid) begin
                chk("hold_real", io.m_real, h_re, 0);
                chk("hold_imag", io.m_imag, h_im, 0);
                chk("hold_index", io.m_index, h_idx, 0);
            end
            if (io.m_valid && io.m_ready) begin
                if (sb.size() == 0) begin
                    fail("unexpected_bin");
                end else begin
                    cur = sb.pop_front();
                    chk($sformatf("bin%0d_index", cur.idx), io.m_index, cur.idx, 0);
                    chk($sformatf("bin%0d_real", cur.idx), io.m_real, cur.re, cur.tol);
                    chk($sformatf("bin%0d_imag", cur.idx), io.m_imag, cur.im, cur.tol);
                    chk($sformatf("bin%0d_last", cur.idx), io.m_last, (cur.idx == 7) ? 1 : 0, 0);
                end
                if (io.m_last) last_edge <= cyc + 1;
            end
            pv <= io.m_valid;
            pstall <= io.m_valid && !io.m_ready;
            h_re <= io.m_real;
            h_im <= io.m_imag;
            h_idx <= io.m_index;
        end
    end

    initial begin
        io.s_valid = 1'b0;
        io.s_real = '0;
        io.s_imag = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_s_ready", io.s_ready, 1, 0);
        chk("rst_m_valid", io.m_valid, 0, 0);
        chk("rst_m_last", io.m_last, 0, 0);
        chk("rst_m_index", io.m_index, 0, 0);
        chk("rst_m_real", io.m_real, 0, 0);
        chk("rst_m_imag", io.m_imag, 0, 0);
        chk("rst_busy", busy, 0, 0);

        // impulse
        set_frame(0, 0);
        fr_re[0] = 1000;
        for (int k = 0; k < 8; k++) push(1000 >>> SH, 0, 0, k);
        send_frame(fa);
        @(negedge clk);
        chk("compute_s_ready", io.s_ready, 0, 0);
        chk("compute_busy", busy, 1, 0);
        drain();

        // DC
        set_frame(1000, 0);
        for (int k = 0; k < 8; k++) push((k == 0) ? (8000 >>> SH) : 0, 0, 0, k);
        send_frame(fa);
        drain();

        // tone at bin 1
        fr_re = '{8192, 5793, 0, -5793, -8192, -5793, 0, 5793};
        fr_im = '{0, 5793, 8192, 5793, 0, -5793, -8192, -5793};
        for (int k = 0; k < 8; k++) push((k == 1) ? (65536 >>> SH) : 0, 0, 3, k);
        send_frame(fa);
        drain();

        // backpressure with an irregular vector
        rdy_mode = 1;
        fr_re = '{1200, -3400, 560, 7800, -910, 2300, -4500, 60};
        fr_im = '{-250, 3100, -70, 400, 1900, -5600, 820, -1300};
        push_model();
        send_frame(fa);
        drain();
        rdy_mode = 0;

        // back-to-back full-scale frames; later frames are offered during COMPUTE/UNLOAD
        set_frame(32767, -32768);
        push_model();
        send_frame(fa);
        fr_re = '{32767, -32768, 32767, -32768, 32767, -32768, 32767, -32768};
        fr_im = '{-32768, 32767, -32768, 32767, -32768, 32767, -32768, 32767};
        push_model();
        send_frame(fb);
        chk("b2b_gap_1", longint'(fb - last_edge), 1, 0);
        fr_re = '{32767, 32767, -32768, -32768, 32767, -32768, 32767, -32768};
        fr_im = '{-32768, 32767, 32767, -32768, -32768, 32767, 32767, -32768};
        push_model();
        send_frame(fa);
        chk("b2b_gap_2", longint'(fa - last_edge), 1, 0);
        drain();

        // reset while butterfly 5 is pending
        set_frame(300, 0);
        send_frame(fa);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("abort_m_valid", io.m_valid, 0, 0);
        chk("abort_busy", busy, 0, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_s_ready", io.s_ready, 1, 0);
        chk("abort_index", io.m_index, 0, 0);
        repeat (40) @(negedge clk);
        chk("abort_no_output", io.m_valid, 0, 0);
        set_frame(500, 0);
        for (int k = 0; k < 8; k++) push((k == 0) ? (4000 >>> SH) : 0, 0, 0, k);
        send_frame(fa);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
